interrupt_ack_sequencer: RTL and testbench
==========================================

// Module: interrupt_ack_sequencer
// PURPOSE
// CPU-side counterpart of the interrupt request register: consumes latched requests,
// resolves priority against the in-service set and raises INT to the CPU.
// Runs the two-pulse INTA handshake, drives the vector byte and owns the in-service
// register (ISR). Returns per-line clear pulses to the request register.
// Sits between the request register and the data-bus buffer inside the PIC.
// PARAMETERS
// SYNC_INTA      1  1: inta_n passes a 2-flop synchronizer; 0: inta_n is already clk-synchronous
// SPURIOUS_LEVEL 7  level reported when no request is valid at the first INTA
// PORTS
// clk              in   1  single clock; all state updates on rising edge
// reset            in   1  synchronous, active-high
// interrupt_req    in   8  latched requests from the request register, bit0 = IR0
// interrupt_mask   in   8  1 = line masked (OCW1)
// vector_base      in   5  ICW2[7:3], upper bits of the vector byte
// auto_eoi         in   1  1: ISR bit is cleared at the end of the second INTA
// inta_n           in   1  CPU interrupt acknowledge, active-low
// eoi_valid        in   1  one-cycle EOI command strobe (OCW2)
// eoi_specific     in   1  1: specific EOI; 0: non-specific EOI
// eoi_level        in   3  target level for a specific EOI
// int_out          out  1  interrupt request to the CPU
// clear_ir_line    out  8  one-cycle clear pulse to the request register
// in_service_reg   out  8  current ISR
// vector_out       out  8  {vector_base, level}
// vector_oe        out  1  data-bus drive enable for vector_out
// BEHAVIOUR
// - Reset: state IDLE; int_out, clear_ir_line, in_service_reg, vector_out and vector_oe all 0.
// - Priority is fully nested and fixed. IR0 is highest.
// - pending = interrupt_req & ~interrupt_mask.
// - A request wins when its level is numerically lower than the highest-priority ISR bit
//   (or the ISR is empty).
// - Edge detection runs on the synchronized inta_n.
//   fall = prev 1, now 0; rise = prev 0, now 1.
// - States:
//   IDLE: a winner exists -> REQ; int_out = 1 on the next cycle.
//   REQ: int_out = 1. On the first fall:
//     - re-resolve the winner and latch its level;
//     - set that ISR bit and pulse clear_ir_line for that bit for one cycle;
//     - int_out = 0; go to ACK1.
//     If no winner exists at that fall (request dropped): latch SPURIOUS_LEVEL,
//     leave the ISR unchanged and emit no clear pulse.
//   ACK1: wait for a rise, then the second fall. On the second fall: vector_oe = 1 and
//     vector_out = {vector_base, latched level}; go to ACK2.
//   ACK2: hold vector_oe = 1 until a rise. On the rise:
//     - vector_oe = 0;
//     - if auto_eoi and the acknowledge was not spurious, clear the latched ISR bit;
//     - go to IDLE.
// - Latency: int_out rises 1 cycle after a winner appears.
//   vector_oe rises 1 cycle after the second fall.
// - EOI is accepted in any state:
//   - Non-specific EOI clears the highest-priority set ISR bit. With the ISR empty it is a no-op.
//   - Specific EOI clears bit eoi_level.
// - If an EOI and the first-fall ISR set land in the same cycle: clear first, then set.
//   The set wins on a shared bit.
// - A request dropping while in REQ does not lower int_out. The handshake completes as spurious.
// - vector_base is sampled at the second fall. Later changes do not alter vector_out in ACK2.
// - Reset asserted mid-handshake: return to IDLE and drop vector_oe and int_out in the same
//   cycle. The ISR clears.
// STRUCTURE
// - pic_pkg: state encoding (IDLE, REQ, ACK1, ACK2), NUM_IR = 8, and
//   function make_vector(base, level).
// - Sub-module priority_resolver (combinational). Inputs: pending, in_service. Outputs:
//   winner_valid, winner_level[2:0], highest_isr_level[2:0]. One instance; the EOI path
//   reuses highest_isr_level.
// TESTING
// - reset; req=8'h08, mask=0, base=5'h10; two INTA pulses -> int_out 1 cycle later;
//   clear_ir_line=8'h08 for one cycle at first fall; ISR=8'h08; vector_out=8'h83.
// - ISR=8'h04 held (no EOI); req=8'h10 -> int_out stays 0.
//   Then req=8'h02 -> int_out=1; acknowledge -> ISR=8'h06, vector level 1.
// - req=8'h01 raised, then dropped before the first fall -> ISR unchanged, no clear pulse,
//   vector_out={base,3'd7}.
// - auto_eoi=1; acknowledge IR5 -> ISR bit5 set at the first fall and cleared on the
//   second INTA rise.
// - ISR=8'h0C; non-specific EOI -> ISR=8'h08; specific EOI level 3 -> ISR=8'h00;
//   non-specific EOI on an empty ISR -> no change.
// - reset asserted in ACK2 -> vector_oe=0, int_out=0, ISR=0 on the next edge; state IDLE.

Source files
------------

// File: rtl/interrupt_ack_sequencer_pkg.sv
// Shared types for the PIC acknowledge sequencer: state encoding,
// line count and vector byte assembly.
package interrupt_ack_sequencer_pkg;

    localparam int NUM_IR = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACK1,
        ST_ACK2
    } state_e;

    function automatic logic [7:0] make_vector(
        input logic [4:0] base,
        input logic [2:0] level
    );
        return {base, level};
    endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_if.sv
// CPU-facing acknowledge bus: INTA strobe in, INT request and vector byte out.
interface interrupt_ack_sequencer_if;

    logic       inta_n;
    logic       int_out;
    logic [7:0] vector_out;
    logic       vector_oe;

    modport master (
        output inta_n,
        input  int_out,
        input  vector_out,
        input  vector_oe
    );

    modport slave (
        input  inta_n,
        output int_out,
        output vector_out,
        output vector_oe
    );

endinterface

// File: rtl/interrupt_ack_sequencer_priority_resolver.sv
// Fixed fully-nested priority: lowest-numbered pending line wins only if it
// outranks the highest-priority in-service level.
module priority_resolver
    import interrupt_ack_sequencer_pkg::*;
(
    input  logic [NUM_IR-1:0] i_pending,
    input  logic [NUM_IR-1:0] i_in_service,
    output logic              o_winner_valid,
    output logic [2:0]        o_winner_level,
    output logic [2:0]        o_highest_isr_level
);

    logic [2:0] w_pend_lvl;
    logic [2:0] w_isr_lvl;
    logic       w_pend_any;
    logic       w_isr_any;

    // Scan high to low so the lowest set index is left standing.
    always_comb begin
        w_pend_lvl = '0;
        w_isr_lvl  = '0;
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            if (i_pending[i])    w_pend_lvl = 3'(i);
            if (i_in_service[i]) w_isr_lvl  = 3'(i);
        end
    end

    assign w_pend_any = |i_pending;
    assign w_isr_any  = |i_in_service;

    assign o_winner_valid      = w_pend_any &&
                                 (!w_isr_any || (w_pend_lvl < w_isr_lvl));
    assign o_winner_level      = w_pend_lvl;
    assign o_highest_isr_level = w_isr_lvl;

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// INT/INTA handshake sequencer: resolves priority, owns the ISR, drives the
// vector byte and returns clear pulses to the request register.
module interrupt_ack_sequencer
    import interrupt_ack_sequencer_pkg::*;
#(
    parameter bit         SYNC_INTA      = 1'b1,
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NUM_IR-1:0]    i_interrupt_req,
    input  logic [NUM_IR-1:0]    i_interrupt_mask,
    input  logic [4:0]           i_vector_base,
    input  logic                 i_auto_eoi,
    input  logic                 i_eoi_valid,
    input  logic                 i_eoi_specific,
    input  logic [2:0]           i_eoi_level,
    output logic [NUM_IR-1:0]    o_clear_ir_line,
    output logic [NUM_IR-1:0]    o_in_service_reg,
    interrupt_ack_sequencer_if.slave cpu
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_inta_s1;
    logic              r_inta_s2;
    logic              r_inta_prev;
    logic              r_rise_seen;
    logic              w_rise_seen_nxt;
    logic [2:0]        r_level;
    logic              r_spurious;
    logic [NUM_IR-1:0] r_isr;
    logic [NUM_IR-1:0] r_clear;
    logic [7:0]        r_vector;

    logic              w_inta;
    logic              w_fall;
    logic              w_rise;
    logic              w_first_ack;
    logic              w_second_ack;
    logic              w_release;
    logic [NUM_IR-1:0] w_pending;
    logic              w_win_valid;
    logic [2:0]        w_win_level;
    logic [2:0]        w_isr_level;
    logic [NUM_IR-1:0] w_isr_set;
    logic [NUM_IR-1:0] w_isr_clr;

    assign w_pending = i_interrupt_req & ~i_interrupt_mask;

    priority_resolver u_resolver (
        .i_pending           (w_pending),
        .i_in_service        (r_isr),
        .o_winner_valid      (w_win_valid),
        .o_winner_level      (w_win_level),
        .o_highest_isr_level (w_isr_level)
    );

    // Idle-high reset values keep the edge detector quiet out of reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_inta_s1   <= 1'b1;
            r_inta_s2   <= 1'b1;
            r_inta_prev <= 1'b1;
        end else begin
            r_inta_s1   <= cpu.inta_n;
            r_inta_s2   <= r_inta_s1;
            r_inta_prev <= w_inta;
        end
    end

    assign w_inta = SYNC_INTA ? r_inta_s2 : cpu.inta_n;
    assign w_fall = r_inta_prev & ~w_inta;
    assign w_rise = ~r_inta_prev & w_inta;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_rise_seen <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rise_seen <= w_rise_seen_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rise_seen_nxt = r_rise_seen;
        w_first_ack     = 1'b0;
        w_second_ack    = 1'b0;
        w_release       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_win_valid) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (w_fall) begin
                    w_first_ack     = 1'b1;
                    w_rise_seen_nxt = 1'b0;
                    w_state_nxt     = ST_ACK1;
                end
            end
            ST_ACK1: begin
                if (w_rise) begin
                    w_rise_seen_nxt = 1'b1;
                end else if (w_fall && r_rise_seen) begin
                    w_second_ack = 1'b1;
                    w_state_nxt  = ST_ACK2;
                end
            end
            ST_ACK2: begin
                if (w_rise) begin
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_isr_set = '0;
        w_isr_clr = '0;
        if (w_first_ack && w_win_valid) w_isr_set[w_win_level] = 1'b1;
        if (i_eoi_valid) begin
            if (i_eoi_specific)  w_isr_clr[i_eoi_level] = 1'b1;
            else if (|r_isr)     w_isr_clr[w_isr_level] = 1'b1;
        end
        if (w_release && i_auto_eoi && !r_spurious) w_isr_clr[r_level] = 1'b1;
    end

    // Clear before set: a set on the same bit in the same cycle survives.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_isr      <= '0;
            r_clear    <= '0;
            r_level    <= '0;
            r_spurious <= 1'b0;
            r_vector   <= '0;
        end else begin
            r_isr   <= (r_isr & ~w_isr_clr) | w_isr_set;
            r_clear <= w_isr_set;
            if (w_first_ack) begin
                r_level    <= w_win_valid ? w_win_level : SPURIOUS_LEVEL;
                r_spurious <= ~w_win_valid;
            end
            if (w_second_ack) r_vector <= make_vector(i_vector_base, r_level);
        end
    end

    assign cpu.int_out       = (r_state == ST_REQ);
    assign cpu.vector_oe     = (r_state == ST_ACK2);
    assign cpu.vector_out    = r_vector;
    assign o_clear_ir_line   = r_clear;
    assign o_in_service_reg  = r_isr;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Scoreboard bench for the acknowledge sequencer: expected clear pulses and
// vector bytes are queued at stimulus time and popped by a monitor.
module tb_interrupt_ack_sequencer;

    typedef struct packed {
        logic       is_vec;
        logic [7:0] val;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic [7:0] mask;
    logic [4:0] base;
    logic       auto_eoi;
    logic       eoi_valid;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic [7:0] clear_ir;
    logic [7:0] isr;

    int   checks;
    int   errors;
    exp_t sb[$];
    logic prev_oe;

    interrupt_ack_sequencer_if bus ();

    interrupt_ack_sequencer dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_interrupt_req  (req),
        .i_interrupt_mask (mask),
        .i_vector_base    (base),
        .i_auto_eoi       (auto_eoi),
        .i_eoi_valid      (eoi_valid),
        .i_eoi_specific   (eoi_specific),
        .i_eoi_level      (eoi_level),
        .o_clear_ir_line  (clear_ir),
        .o_in_service_reg (isr),
        .cpu              (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every clear pulse cycle and every vector_oe rise consumes one entry.
    initial prev_oe = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (clear_ir != 8'h00) begin
            if (sb.size() == 0 || sb[0].is_vec) begin
                checks++;
                errors++;
                $display("FAIL clear_unexpected: got %02h expected none", clear_ir);
            end else begin
                e = sb.pop_front();
                check("clear_ir_line", clear_ir, e.val);
            end
        end
        if (bus.vector_oe && !prev_oe) begin
            if (sb.size() == 0 || !sb[0].is_vec) begin
                checks++;
                errors++;
                $display("FAIL vector_unexpected: got %02h expected none", bus.vector_out);
            end else begin
                e = sb.pop_front();
                check("vector_out", bus.vector_out, e.val);
            end
        end
        prev_oe = bus.vector_oe;
    end

    task automatic raise(input logic [7:0] r);
        req = r;
        check("int_before", {7'd0, bus.int_out}, 8'h00);
        tick(1);
        check("int_after", {7'd0, bus.int_out}, 8'h01);
    endtask

    // Two INTA pulses; the request register drops the acknowledged line.
    task automatic ack(input logic [7:0] exp_clr, input logic [7:0] mid_isr,
                       input logic [7:0] exp_vec, input bit stop_in_ack2);
        logic [4:0] saved;
        if (exp_clr != 8'h00) sb.push_back('{1'b0, exp_clr});
        sb.push_back('{1'b1, exp_vec});
        bus.inta_n = 1'b0;
        tick(4);
        req = req & ~exp_clr;
        check("int_dropped", {7'd0, bus.int_out}, 8'h00);
        check("isr_mid", isr, mid_isr);
        bus.inta_n = 1'b1;
        tick(4);
        bus.inta_n = 1'b0;
        tick(4);
        check("oe_ack2", {7'd0, bus.vector_oe}, 8'h01);
        saved = base;
        base  = 5'h1F;
        tick(1);
        check("vector_held", bus.vector_out, exp_vec);
        base = saved;
        if (!stop_in_ack2) begin
            bus.inta_n = 1'b1;
            tick(4);
            check("oe_released", {7'd0, bus.vector_oe}, 8'h00);
        end
    endtask

    task automatic eoi(input bit specific, input logic [2:0] lvl);
        eoi_valid    = 1'b1;
        eoi_specific = specific;
        eoi_level    = lvl;
        tick(1);
        eoi_valid    = 1'b0;
        eoi_specific = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        req          = 8'h00;
        mask         = 8'h00;
        base         = 5'h10;
        auto_eoi     = 1'b0;
        eoi_valid    = 1'b0;
        eoi_specific = 1'b0;
        eoi_level    = 3'd0;
        bus.inta_n   = 1'b1;
        tick(3);
        check("rst_int", {7'd0, bus.int_out}, 8'h00);
        check("rst_clear", clear_ir, 8'h00);
        check("rst_isr", isr, 8'h00);
        check("rst_vec", bus.vector_out, 8'h00);
        check("rst_oe", {7'd0, bus.vector_oe}, 8'h00);
        reset = 1'b0;
        tick(2);

        raise(8'h08);
        ack(8'h08, 8'h08, 8'h83, 1'b0);
        check("isr_ir3", isr, 8'h08);

        eoi(1'b1, 3'd3);
        check("isr_eoi3", isr, 8'h00);
        raise(8'h04);
        ack(8'h04, 8'h04, 8'h82, 1'b0);
        req = 8'h10;
        tick(3);
        check("int_blocked", {7'd0, bus.int_out}, 8'h00);
        raise(8'h02);
        ack(8'h02, 8'h06, 8'h81, 1'b0);
        check("isr_nested", isr, 8'h06);
        req = 8'h00;

        eoi(1'b0, 3'd0);
        check("isr_ns1", isr, 8'h04);
        eoi(1'b0, 3'd0);
        check("isr_ns2", isr, 8'h00);
        eoi(1'b0, 3'd0);
        check("isr_ns_empty", isr, 8'h00);

        raise(8'h01);
        req = 8'h00;
        tick(2);
        check("int_held", {7'd0, bus.int_out}, 8'h01);
        ack(8'h00, 8'h00, 8'h87, 1'b0);
        check("isr_spurious", isr, 8'h00);

        auto_eoi = 1'b1;
        raise(8'h20);
        ack(8'h20, 8'h20, 8'h85, 1'b0);
        check("isr_auto", isr, 8'h00);
        auto_eoi = 1'b0;

        raise(8'h08);
        ack(8'h08, 8'h08, 8'h83, 1'b0);
        raise(8'h04);
        ack(8'h04, 8'h0C, 8'h82, 1'b0);
        check("isr_0c", isr, 8'h0C);
        eoi(1'b0, 3'd0);
        check("isr_0c_ns", isr, 8'h08);
        eoi(1'b1, 3'd3);
        check("isr_0c_sp", isr, 8'h00);

        raise(8'h02);
        ack(8'h02, 8'h02, 8'h81, 1'b1);
        reset = 1'b1;
        tick(1);
        check("rst_ack2_oe", {7'd0, bus.vector_oe}, 8'h00);
        check("rst_ack2_int", {7'd0, bus.int_out}, 8'h00);
        check("rst_ack2_isr", isr, 8'h00);
        reset      = 1'b0;
        bus.inta_n = 1'b1;
        tick(4);
        check("idle_after_rst", {7'd0, bus.int_out}, 8'h00);
        check("idle_oe", {7'd0, bus.vector_oe}, 8'h00);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
